// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the UART pattern-memory loader.
//   ld_state_t   : packet FSM states (IDLE, LEN, DATA, CSUM)
//   rx_state_t   : UART receiver frame states
//   SYNC_BYTE    : first byte of every packet
//   clks_per_bit : clock cycles per UART bit for a given clock and baud rate
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 2-flop synchronizer, bit timer and LSB-first shift
// register. Runs continuously, independent of the packet layer.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset (aborts any frame in progress)
//   rx         : asynchronous serial input, idles high
//   byte_valid : one-cycle pulse at the stop-bit centre for a good frame
//   byte_data  : received byte, valid with byte_valid
//   frame_err  : one-cycle pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_r;
    rx_state_t        state_next_s;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             cnt_hit_s;

    // Sample point: half a bit into the start bit, then every full bit period.
    always_comb begin
        cnt_hit_s = 1'b0;
        if (state_r == RX_START) begin
            cnt_hit_s = (cnt_r == HALF_LAST);
        end else begin
            cnt_hit_s = (cnt_r == FULL_LAST);
        end
    end

    // Frame state transitions.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    state_next_s = RX_START;
                end else begin
                    state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                // A line back high at mid start bit is a glitch, not a frame.
                if (cnt_hit_s) begin
                    if (rx_sync_r) begin
                        state_next_s = RX_IDLE;
                    end else begin
                        state_next_s = RX_DATA;
                    end
                end else begin
                    state_next_s = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_hit_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = RX_STOP;
                end else begin
                    state_next_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_hit_s) begin
                    state_next_s = RX_IDLE;
                end else begin
                    state_next_s = RX_STOP;
                end
            end
            default: state_next_s = RX_IDLE;
        endcase
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Synchronizer, bit timer, shift register and registered byte outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if ((state_r == RX_IDLE) || cnt_hit_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (state_r == RX_START) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == RX_DATA) && cnt_hit_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
                shift_r   <= {rx_sync_r, shift_r[7:1]};
            end

            if ((state_r == RX_STOP) && cnt_hit_s) begin
                if (rx_sync_r) begin
                    byte_valid <= 1'b1;
                    byte_data  <= shift_r;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
// Loads the LED pattern memory from a UART packet stream:
//   0xA5, LEN, LEN data bytes, CSUM (XOR of the data bytes).
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset
//   rx    : UART receive line (asynchronous, idles high)
//   we    : memory write strobe, one cycle per word
//   waddr : write address (holds when we=0)
//   wdata : write data, low DATA_W bits of the data byte (holds when we=0)
//   busy  : high from sync-byte acceptance until return to IDLE
//   done  : one-cycle pulse on a packet with a good checksum
//   err   : one-cycle pulse on protocol, framing or timeout error
// -----------------------------------------------------------------------------
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 3,
    parameter int DEPTH        = 21,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W         = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);

    logic              byte_valid_s;
    logic [7:0]        byte_data_s;
    logic              frame_err_s;

    ld_state_t         state_r;
    ld_state_t         state_next_s;
    logic [7:0]        len_r;
    logic [7:0]        byte_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        xor_r;
    logic [TO_W-1:0]   idle_cnt_r;

    logic              load_len_s;
    logic              wr_s;
    logic              done_s;
    logic              err_s;
    logic              timeout_s;
    logic              last_byte_s;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .frame_err  (frame_err_s)
    );

    assign timeout_s   = (state_r != IDLE) && (idle_cnt_r == TO_LAST);
    assign last_byte_s = (byte_cnt_r == (len_r - 8'd1));

    // Packet FSM next state and per-cycle actions. A framing error aborts
    // from any state; a received byte always wins over a coincident timeout.
    always_comb begin
        state_next_s = state_r;
        load_len_s   = 1'b0;
        wr_s         = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        if (frame_err_s) begin
            err_s        = 1'b1;
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (byte_valid_s && (byte_data_s == SYNC_BYTE)) begin
                        state_next_s = LEN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                LEN: begin
                    if (byte_valid_s) begin
                        if ((byte_data_s == 8'd0) || (byte_data_s > DEPTH_B)) begin
                            err_s        = 1'b1;
                            state_next_s = IDLE;
                        end else begin
                            load_len_s   = 1'b1;
                            state_next_s = DATA;
                        end
                    end else if (timeout_s) begin
                        err_s        = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = LEN;
                    end
                end
                DATA: begin
                    if (byte_valid_s) begin
                        wr_s = 1'b1;
                        if (last_byte_s) begin
                            state_next_s = CSUM;
                        end else begin
                            state_next_s = DATA;
                        end
                    end else if (timeout_s) begin
                        err_s        = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DATA;
                    end
                end
                CSUM: begin
                    if (byte_valid_s) begin
                        if (byte_data_s == xor_r) begin
                            done_s = 1'b1;
                        end else begin
                            err_s  = 1'b1;
                        end
                        state_next_s = IDLE;
                    end else if (timeout_s) begin
                        err_s        = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = CSUM;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters, running XOR, idle timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r      <= 8'd0;
            byte_cnt_r <= 8'd0;
            addr_r     <= {ADDR_W{1'b0}};
            xor_r      <= 8'd0;
            idle_cnt_r <= {TO_W{1'b0}};
            we         <= 1'b0;
            waddr      <= {ADDR_W{1'b0}};
            wdata      <= {DATA_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            we   <= wr_s;
            done <= done_s;
            err  <= err_s;
            // Busy tracks the state being entered so it drops with done/err.
            busy <= (state_next_s != IDLE);

            if (load_len_s) begin
                len_r      <= byte_data_s;
                byte_cnt_r <= 8'd0;
                addr_r     <= {ADDR_W{1'b0}};
                xor_r      <= 8'd0;
            end else if (wr_s) begin
                waddr      <= addr_r;
                wdata      <= byte_data_s[DATA_W-1:0];
                xor_r      <= xor_r ^ byte_data_s;
                byte_cnt_r <= byte_cnt_r + 8'd1;
                // Stop on the last word so the counter stays within DEPTH-1.
                if (!last_byte_s) begin
                    addr_r <= addr_r + ADDR_W'(1);
                end else begin
                    addr_r <= addr_r;
                end
            end

            if ((state_r == IDLE) || byte_valid_s || (state_next_s != state_r)) begin
                idle_cnt_r <= {TO_W{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for uart_mem_loader. A fast baud rate keeps runs short;
// all timing expectations derive from the same parameters.
module tb_uart_mem_loader;

    localparam int CLK_HZ       = 12_000_000;
    localparam int BAUD         = 1_000_000;
    localparam int CPB          = CLK_HZ / BAUD;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 3;
    localparam int DEPTH        = 21;
    localparam int TIMEOUT_BITS = 20;
    localparam int TO_CYC       = TIMEOUT_BITS * CPB;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    // observed activity
    logic [7:0] obs_wr[$];
    int done_cnt = 0, err_cnt = 0;
    int hold_bad = 0, excl_bad = 0, width_bad = 0, busy_bad = 0;
    logic [7:0] last_wr = 8'h00;
    logic prev_done = 1'b0, prev_err = 1'b0;

    // reference model results
    logic [7:0] exp_wr[$];
    int exp_done = 0, exp_err = 0;

    uart_mem_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (we) obs_wr.push_back({waddr, wdata});
            else if ({waddr, wdata} !== last_wr) hold_bad++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done && err) excl_bad++;
            if ((done && prev_done) || (err && prev_err)) width_bad++;
            if ((done || err) && busy) busy_bad++;
            if (we && !busy) busy_bad++;
        end
        last_wr   = {waddr, wdata};
        prev_done = done;
        prev_err  = err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: the effect of one complete packet.
    task automatic model_packet(input bq_t d, input logic [7:0] len, input logic [7:0] cs);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        if (len == 8'd0 || int'(len) > DEPTH) begin
            exp_err++;
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                b = d[i];
                exp_wr.push_back({5'(i), b[2:0]});
                x = x ^ b;
            end
            if (x == cs) exp_done++;
            else exp_err++;
        end
    endtask

    // Called on a falling edge; drives one 8N1 frame and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_packet(input bq_t d, input logic [7:0] len, input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte(len, 1'b1);
        if (len != 8'd0 && int'(len) <= DEPTH) begin
            for (int i = 0; i < int'(len); i++) send_byte(d[i], 1'b1);
            send_byte(cs, 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_checks += 6;
        if (we !== 1'b0)    begin n_errors++; $display("FAIL reset_we: got %b want 0", we); end
        if (waddr !== 5'd0) begin n_errors++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        if (wdata !== 3'd0) begin n_errors++; $display("FAIL reset_wdata: got %0d want 0", wdata); end
        if (busy !== 1'b0)  begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)  begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== 1'b0)   begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_valid_load();
        bq_t d;
        int wb;
        d = '{8'h01, 8'h02, 8'h04};
        wb = exp_wr.size();
        model_packet(d, 8'd3, 8'h07);
        send_packet(d, 8'd3, 8'h07);
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL valid_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        for (int i = wb; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i]) begin n_errors++; $display("FAIL valid_wr%0d: got addr %0d data %0d want addr %0d data %0d", i, obs_wr[i][7:3], obs_wr[i][2:0], exp_wr[i][7:3], exp_wr[i][2:0]); end
        end
        n_checks += 3;
        if (done_cnt !== exp_done) begin n_errors++; $display("FAIL valid_done: got %0d want %0d", done_cnt, exp_done); end
        if (err_cnt !== exp_err)   begin n_errors++; $display("FAIL valid_err: got %0d want %0d", err_cnt, exp_err); end
        if (busy !== 1'b0)         begin n_errors++; $display("FAIL valid_busy: got %b want 0", busy); end
    endtask

    task automatic test_bad_checksum();
        bq_t d;
        int wb;
        d = '{8'h05, 8'h06};
        wb = exp_wr.size();
        model_packet(d, 8'd2, 8'h00);
        send_packet(d, 8'd2, 8'h00);
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL badcs_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        for (int i = wb; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i]) begin n_errors++; $display("FAIL badcs_wr%0d: got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
        n_checks += 3;
        if (done_cnt !== exp_done) begin n_errors++; $display("FAIL badcs_done: got %0d want %0d", done_cnt, exp_done); end
        if (err_cnt !== exp_err)   begin n_errors++; $display("FAIL badcs_err: got %0d want %0d", err_cnt, exp_err); end
        if (busy !== 1'b0)         begin n_errors++; $display("FAIL badcs_busy: got %b want 0", busy); end
    endtask

    task automatic test_bad_length();
        bq_t d;
        int wb;
        d = '{};
        model_packet(d, 8'h00, 8'h00);
        send_packet(d, 8'h00, 8'h00);
        model_packet(d, 8'h16, 8'h00);
        send_packet(d, 8'h16, 8'h00);
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL badlen_err: got %0d want %0d", err_cnt, exp_err); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL badlen_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        d = '{8'h03, 8'h07, 8'h0E, 8'h11};
        wb = exp_wr.size();
        model_packet(d, 8'd4, 8'h03 ^ 8'h07 ^ 8'h0E ^ 8'h11);
        send_packet(d, 8'd4, 8'h03 ^ 8'h07 ^ 8'h0E ^ 8'h11);
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL badlen_follow_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        if (done_cnt !== exp_done)           begin n_errors++; $display("FAIL badlen_follow_done: got %0d want %0d", done_cnt, exp_done); end
        for (int i = wb; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i]) begin n_errors++; $display("FAIL badlen_follow_wr%0d: got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL frame_busy_rise: got %b want 1", busy); end
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b0);
        exp_err++;
        repeat (4) @(negedge clk);
        n_checks += 3;
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL frame_err: got %0d want %0d", err_cnt, exp_err); end
        if (busy !== 1'b0)                   begin n_errors++; $display("FAIL frame_busy: got %b want 0", busy); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL frame_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        // back in IDLE: a plain data byte must be ignored
        send_byte(8'h03, 1'b1);
        repeat (4) @(negedge clk);
        n_checks += 2;
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL frame_idle_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL frame_idle_err: got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_timeout();
        int t_bv;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_wr.push_back({5'd0, 3'd1});
        t_bv = start_cyc + (19 * CPB) / 2;
        while (cyc < t_bv + TO_CYC) @(negedge clk);
        n_checks += 2;
        if (err_cnt !== exp_err) begin n_errors++; $display("FAIL timeout_early: got %0d errs want %0d", err_cnt, exp_err); end
        if (busy !== 1'b1)       begin n_errors++; $display("FAIL timeout_busy_hold: got %b want 1", busy); end
        exp_err++;
        while (cyc < t_bv + TO_CYC + 8) @(negedge clk);
        n_checks += 3;
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, exp_err); end
        if (busy !== 1'b0)                   begin n_errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL timeout_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_reset_midbyte();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_wr.push_back({5'd0, 3'd1});
        rx = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks += 6;
        if (we !== 1'b0)    begin n_errors++; $display("FAIL rstmid_we: got %b want 0", we); end
        if (waddr !== 5'd0) begin n_errors++; $display("FAIL rstmid_waddr: got %0d want 0", waddr); end
        if (wdata !== 3'd0) begin n_errors++; $display("FAIL rstmid_wdata: got %0d want 0", wdata); end
        if (busy !== 1'b0)  begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (done !== 1'b0)  begin n_errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        if (err !== 1'b0)   begin n_errors++; $display("FAIL rstmid_err: got %b want 0", err); end
        rst = 1'b0;
        rx  = 1'b1;
        repeat (TO_CYC + 4 * CPB) @(negedge clk);
        n_checks += 3;
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL rstmid_no_err: got %0d want %0d", err_cnt, exp_err); end
        if (done_cnt !== exp_done)           begin n_errors++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, exp_done); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL rstmid_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_glitch_junk();
        bq_t d;
        logic [7:0] cs;
        int wb;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        n_checks += 3;
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL glitch_err: got %0d want %0d", err_cnt, exp_err); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL glitch_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        if (busy !== 1'b0)                   begin n_errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL junk_busy: got %b want 0", busy); end
        d = '{8'h06, 8'hF3};
        cs = 8'h06 ^ 8'hF3;
        wb = exp_wr.size();
        model_packet(d, 8'd2, cs);
        send_packet(d, 8'd2, cs);
        repeat (4) @(negedge clk);
        n_checks += 3;
        if (done_cnt !== exp_done)           begin n_errors++; $display("FAIL junk_done: got %0d want %0d", done_cnt, exp_done); end
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL junk_err: got %0d want %0d", err_cnt, exp_err); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL junk_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
        for (int i = wb; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== exp_wr[i]) begin n_errors++; $display("FAIL junk_wr%0d: got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bq_t d1, d2;
        int db;
        d1 = '{8'h11, 8'h22, 8'h33};
        d2 = '{8'h7F};
        db = exp_done;
        model_packet(d1, 8'd3, 8'h11 ^ 8'h22 ^ 8'h33);
        model_packet(d2, 8'd1, 8'h7F);
        send_packet(d1, 8'd3, 8'h11 ^ 8'h22 ^ 8'h33);
        send_packet(d2, 8'd1, 8'h7F);
        repeat (4) @(negedge clk);
        n_checks += 3;
        if (done_cnt !== db + 2)             begin n_errors++; $display("FAIL b2b_done: got %0d want %0d", done_cnt, db + 2); end
        if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL b2b_err: got %0d want %0d", err_cnt, exp_err); end
        if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL b2b_nwr: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            bq_t d;
            logic [7:0] len;
            logic [7:0] cs;
            int mode;
            int wb;
            mode = $urandom_range(0, 9);
            len  = 8'($urandom_range(1, DEPTH));
            if (mode == 0) len = 8'(DEPTH + 1 + $urandom_range(0, 60));
            if (p == 5) len = 8'(DEPTH);
            d  = '{};
            cs = 8'h00;
            for (int i = 0; i < int'(len) && int'(len) <= DEPTH; i++) begin
                d.push_back(8'($urandom));
                cs = cs ^ d[i];
            end
            if (mode == 1 || mode == 2) cs = cs ^ (8'h01 << $urandom_range(0, 7));
            wb = exp_wr.size();
            model_packet(d, len, cs);
            send_packet(d, len, cs);
            repeat (4) @(negedge clk);
            n_checks += 3;
            if (done_cnt !== exp_done)           begin n_errors++; $display("FAIL rand%0d_done: got %0d want %0d", p, done_cnt, exp_done); end
            if (err_cnt !== exp_err)             begin n_errors++; $display("FAIL rand%0d_err: got %0d want %0d", p, err_cnt, exp_err); end
            if (obs_wr.size() !== exp_wr.size()) begin n_errors++; $display("FAIL rand%0d_nwr: got %0d want %0d", p, obs_wr.size(), exp_wr.size()); end
            for (int i = wb; i < exp_wr.size() && i < obs_wr.size(); i++) begin
                n_checks++;
                if (obs_wr[i] !== exp_wr[i]) begin n_errors++; $display("FAIL rand%0d_wr%0d: got %h want %h", p, i, obs_wr[i], exp_wr[i]); end
            end
        end
    endtask

    task automatic test_invariants();
        n_checks += 4;
        if (hold_bad !== 0)  begin n_errors++; $display("FAIL hold_when_idle: got %0d changes want 0", hold_bad); end
        if (excl_bad !== 0)  begin n_errors++; $display("FAIL done_err_exclusive: got %0d overlaps want 0", excl_bad); end
        if (width_bad !== 0) begin n_errors++; $display("FAIL pulse_width: got %0d long pulses want 0", width_bad); end
        if (busy_bad !== 0)  begin n_errors++; $display("FAIL busy_timing: got %0d violations want 0", busy_bad); end
    endtask

    initial begin
        test_reset();
        test_valid_load();
        test_bad_checksum();
        test_bad_length();
        test_framing();
        test_timeout();
        test_reset_midbyte();
        test_glitch_junk();
        test_back_to_back();
        test_random();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
